// File: rtl/axi2mem_rd_tcdm_unit.sv
// Read-side TCDM back end: queues per-lane read commands, issues TCDM reads under a credit limit,
// and pairs the two lanes' returned words into 64-bit beats tagged with id/last.
module axi2mem_rd_tcdm_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int CMD_DEPTH  = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 trans_req_i,
    input  logic [1:0][ADDR_WIDTH-1:0] trans_add_i,
    input  logic [1:0][ID_WIDTH-1:0]   trans_id_i,
    input  logic [1:0]                 trans_last_i,
    output logic [1:0]                 trans_gnt_o,
    output logic [1:0]                 tcdm_req_o,
    output logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o,
    output logic [1:0]                 tcdm_wen_o,
    output logic [1:0][3:0]            tcdm_be_o,
    output logic [1:0][31:0]           tcdm_wdata_o,
    input  logic [1:0]                 tcdm_gnt_i,
    input  logic [1:0]                 tcdm_r_valid_i,
    input  logic [1:0][31:0]           tcdm_r_rdata_i,
    output logic [63:0]                data_dat_o,
    output logic [ID_WIDTH-1:0]        data_id_o,
    output logic                       data_last_o,
    output logic                       data_gnt_o,
    input  logic                       data_req_i
);

    // Handshakes: a command moves on trans_req_i & trans_gnt_o, a TCDM read on tcdm_req_o & tcdm_gnt_i,
    // and a beat on data_req_i & data_gnt_o; every ready/grant depends on registered state only.
    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RESP_DEPTH);
    localparam int OW  = $clog2(RESP_DEPTH + 1);

    logic [1:0]               rsp_empty;
    logic [1:0][31:0]         rsp_dat_head;
    logic [1:0][ID_WIDTH-1:0] rsp_id_head;
    logic [1:0]               rsp_last_head;
    logic                     rsp_pop;

    assign rsp_pop      = data_req_i & data_gnt_o;
    assign tcdm_wen_o   = 2'b11;
    assign tcdm_be_o    = {4'hF, 4'hF};
    assign tcdm_wdata_o = '0;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [ADDR_WIDTH-1:0] cmd_add_q  [CMD_DEPTH];
        logic [ID_WIDTH-1:0]   cmd_id_q   [CMD_DEPTH];
        logic                  cmd_last_q [CMD_DEPTH];
        logic [CPW-1:0]        cmd_wr_q, cmd_rd_q;
        logic [CPW:0]          cmd_cnt_q;

        logic [31:0]           rsp_dat_q  [RESP_DEPTH];
        logic [ID_WIDTH-1:0]   rsp_id_q   [RESP_DEPTH];
        logic                  rsp_last_q [RESP_DEPTH];
        logic [RPW-1:0]        rsp_wr_q, rsp_rd_q;
        logic [RPW:0]          rsp_cnt_q;

        logic                  inflight_q;
        logic [ID_WIDTH-1:0]   tag_id_q;
        logic                  tag_last_q;
        logic [OW-1:0]         occ;
        logic                  cmd_push, cmd_pop, rsp_push, cmd_empty;

        assign cmd_empty      = (cmd_cnt_q == '0);
        assign trans_gnt_o[l] = (cmd_cnt_q != (CPW+1)'(CMD_DEPTH));
        assign cmd_push       = trans_req_i[l] & trans_gnt_o[l];
        assign cmd_pop        = tcdm_req_o[l] & tcdm_gnt_i[l];
        // A read returning with nothing outstanding (e.g. straggler across reset) is dropped.
        assign rsp_push       = tcdm_r_valid_i[l] & inflight_q;

        // Credits cover the outstanding read plus everything already buffered.
        assign occ            = OW'(rsp_cnt_q) + OW'(inflight_q);
        assign tcdm_req_o[l]  = !cmd_empty && (occ < OW'(RESP_DEPTH));
        assign tcdm_add_o[l]  = tcdm_req_o[l] ? cmd_add_q[cmd_rd_q] : '0;

        assign rsp_empty[l]     = (rsp_cnt_q == '0);
        assign rsp_dat_head[l]  = rsp_dat_q[rsp_rd_q];
        assign rsp_id_head[l]   = rsp_id_q[rsp_rd_q];
        assign rsp_last_head[l] = rsp_last_q[rsp_rd_q];

        always_ff @(posedge clk_i) begin
            if (cmd_push) begin
                cmd_add_q[cmd_wr_q]  <= trans_add_i[l];
                cmd_id_q[cmd_wr_q]   <= trans_id_i[l];
                cmd_last_q[cmd_wr_q] <= trans_last_i[l];
            end
            if (rsp_push) begin
                rsp_dat_q[rsp_wr_q]  <= tcdm_r_rdata_i[l];
                rsp_id_q[rsp_wr_q]   <= tag_id_q;
                rsp_last_q[rsp_wr_q] <= tag_last_q;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cmd_wr_q   <= '0;
                cmd_rd_q   <= '0;
                cmd_cnt_q  <= '0;
                rsp_wr_q   <= '0;
                rsp_rd_q   <= '0;
                rsp_cnt_q  <= '0;
                inflight_q <= 1'b0;
                tag_id_q   <= '0;
                tag_last_q <= 1'b0;
            end else begin
                if (cmd_push) cmd_wr_q <= cmd_wr_q + CPW'(1);
                if (cmd_pop)  cmd_rd_q <= cmd_rd_q + CPW'(1);
                cmd_cnt_q <= cmd_cnt_q + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_pop);
                if (rsp_push) rsp_wr_q <= rsp_wr_q + RPW'(1);
                if (rsp_pop)  rsp_rd_q <= rsp_rd_q + RPW'(1);
                rsp_cnt_q <= rsp_cnt_q + (RPW+1)'(rsp_push) - (RPW+1)'(rsp_pop);
                // A new grant wins over the returning read so back-to-back reads stay tracked.
                if (cmd_pop) begin
                    inflight_q <= 1'b1;
                    tag_id_q   <= cmd_id_q[cmd_rd_q];
                    tag_last_q <= cmd_last_q[cmd_rd_q];
                end else if (rsp_push) begin
                    inflight_q <= 1'b0;
                end
            end
        end

        a_rvalid_inflight: assert property (@(posedge clk_i) disable iff (!rst_ni)
            tcdm_r_valid_i[l] |-> inflight_q);
        a_occ_limit: assert property (@(posedge clk_i) disable iff (!rst_ni)
            occ <= OW'(RESP_DEPTH));
    end

    assign data_gnt_o  = !rsp_empty[0] & !rsp_empty[1];
    assign data_dat_o  = data_gnt_o ? {rsp_dat_head[1], rsp_dat_head[0]} : '0;
    assign data_id_o   = data_gnt_o ? rsp_id_head[0] : '0;
    assign data_last_o = data_gnt_o & rsp_last_head[0];

    a_pop_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_req_i |-> data_gnt_o);
    a_lane_tags_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_gnt_o |-> (rsp_id_head[0] == rsp_id_head[1] && rsp_last_head[0] == rsp_last_head[1]));

endmodule

// File: tb/tb_axi2mem_rd_tcdm_unit.sv
// Bench for axi2mem_rd_tcdm_unit: table of single beats, directed multi-cycle corners and a
// randomized run, all checked against a per-lane command queue scoreboard and a TCDM memory model.
module tb_axi2mem_rd_tcdm_unit;

    logic                 clk;
    logic                 rst_ni;
    logic [1:0]           trans_req_i;
    logic [1:0][31:0]     trans_add_i;
    logic [1:0][5:0]      trans_id_i;
    logic [1:0]           trans_last_i;
    logic [1:0]           trans_gnt_o;
    logic [1:0]           tcdm_req_o;
    logic [1:0][31:0]     tcdm_add_o;
    logic [1:0]           tcdm_wen_o;
    logic [1:0][3:0]      tcdm_be_o;
    logic [1:0][31:0]     tcdm_wdata_o;
    logic [1:0]           tcdm_gnt_i;
    logic [1:0]           tcdm_r_valid_i;
    logic [1:0][31:0]     tcdm_r_rdata_i;
    logic [63:0]          data_dat_o;
    logic [5:0]           data_id_o;
    logic                 data_last_o;
    logic                 data_gnt_o;
    logic                 data_req_i;

    axi2mem_rd_tcdm_unit dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .trans_req_i(trans_req_i), .trans_add_i(trans_add_i), .trans_id_i(trans_id_i),
        .trans_last_i(trans_last_i), .trans_gnt_o(trans_gnt_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
        .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o), .tcdm_gnt_i(tcdm_gnt_i),
        .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
        .data_dat_o(data_dat_o), .data_id_o(data_id_o), .data_last_o(data_last_o),
        .data_gnt_o(data_gnt_o), .data_req_i(data_req_i)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] add0;
        logic [31:0] add1;
        logic [5:0]  id;
        logic        last;
        logic [63:0] exp_dat;
        logic [5:0]  exp_id;
        logic        exp_last;
        int          exp_lat;
    } vec_t;

    vec_t         vecs[4];
    int           n_vec, n_err;
    logic [38:0]  exp_q0[$];
    logic [38:0]  exp_q1[$];
    int           acc[2];
    int           gcnt[2];
    int           pops;
    logic [31:0]  b_add[64];
    logic [5:0]   b_id[64];
    logic         b_last[64];

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hAAAA_0000;
        if (a == 32'h0000_0104) return 32'hBBBB_1111;
        return {a[15:0] ^ 16'h5AC3, ~a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: predict this edge's handshakes, scoreboard them, then model the TCDM reply.
    task automatic tick();
        logic [1:0]       rv;
        logic [1:0][31:0] rd;
        logic [38:0]      e0, e1;
        for (int l = 0; l < 2; l++) begin
            rv[l] = rst_ni && tcdm_req_o[l] && tcdm_gnt_i[l];
            rd[l] = mem(tcdm_add_o[l]);
            if (rv[l]) gcnt[l]++;
            if (rst_ni && trans_req_i[l] && trans_gnt_o[l]) begin
                if (l == 0) exp_q0.push_back({trans_last_i[0], trans_id_i[0], trans_add_i[0]});
                else        exp_q1.push_back({trans_last_i[1], trans_id_i[1], trans_add_i[1]});
                acc[l]++;
            end
        end
        if (rst_ni && data_req_i && data_gnt_o) begin
            if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_order: beat popped with no expected command pair");
            end else begin
                e0 = exp_q0.pop_front();
                e1 = exp_q1.pop_front();
                chk("beat", {9'b0, data_last_o, data_id_o, data_dat_o},
                    {9'b0, e0[38], e0[37:32], mem(e1[31:0]), mem(e0[31:0])});
                pops++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        tcdm_r_valid_i = rv;
        tcdm_r_rdata_i = rd;
    endtask

    task automatic drive_beat(input int l);
        trans_add_i[l]  = b_add[acc[l]] + ((l == 1) ? 32'd4 : 32'd0);
        trans_id_i[l]   = b_id[acc[l]];
        trans_last_i[l] = b_last[acc[l]];
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        trans_req_i = 2'b00;
        tcdm_gnt_i  = 2'b11;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && c < 300) begin
            data_req_i = data_gnt_o;
            tick();
            c++;
        end
        data_req_i = 1'b0;
        chk({name, "_drained"}, 80'(exp_q0.size() + exp_q1.size()), 80'd0);
    endtask

    task automatic single_beat(input vec_t v, input string name);
        int lat;
        trans_req_i  = 2'b11;
        trans_add_i  = {v.add1, v.add0};
        trans_id_i   = {v.id, v.id};
        trans_last_i = {v.last, v.last};
        tcdm_gnt_i   = 2'b11;
        data_req_i   = 1'b0;
        tick();
        trans_req_i = 2'b00;
        lat = 1;
        while (!data_gnt_o && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 80'(lat), 80'(v.exp_lat));
        chk({name, "_dat"}, 80'(data_dat_o), 80'(v.exp_dat));
        chk({name, "_id"}, 80'(data_id_o), 80'(v.exp_id));
        chk({name, "_last"}, 80'(data_last_o), 80'(v.exp_last));
        data_req_i = data_gnt_o;
        tick();
        data_req_i = 1'b0;
        chk({name, "_gnt_after_pop"}, 80'(data_gnt_o), 80'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_trans_gnt"}, 80'(trans_gnt_o), 80'(2'b11));
        chk({name, "_tcdm_req"}, 80'(tcdm_req_o), 80'd0);
        chk({name, "_tcdm_add"}, 80'(tcdm_add_o), 80'd0);
        chk({name, "_data_gnt"}, 80'(data_gnt_o), 80'd0);
        chk({name, "_data_out"}, {9'b0, data_last_o, data_id_o, data_dat_o}, 80'd0);
    endtask

    initial begin
        int ones, tg_bad, tr_ones, gbad, c;
        logic [31:0] ra;

        vecs[0] = '{32'h100, 32'h104, 6'd5, 1'b1, 64'hBBBB1111_AAAA0000, 6'd5, 1'b1, 3};
        vecs[1] = '{32'h0, 32'h4, 6'd0, 1'b0, {mem(32'h4), mem(32'h0)}, 6'd0, 1'b0, 3};
        vecs[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 6'd63, 1'b1,
                    {mem(32'hFFFF_FFFC), mem(32'hFFFF_FFF8)}, 6'd63, 1'b1, 3};
        vecs[3] = '{32'h1230, 32'h1234, 6'd42, 1'b0, {mem(32'h1234), mem(32'h1230)}, 6'd42, 1'b0, 3};

        n_vec = 0; n_err = 0; pops = 0;
        acc = '{0, 0}; gcnt = '{0, 0};
        rst_ni = 1'b0;
        trans_req_i = '0; trans_add_i = '0; trans_id_i = '0; trans_last_i = '0;
        tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_rdata_i = '0; data_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("tie_wen", 80'(tcdm_wen_o), 80'(2'b11));
        chk("tie_be", 80'(tcdm_be_o), 80'(8'hFF));
        chk("tie_wdata", 80'(tcdm_wdata_o), 80'd0);
        rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) single_beat(vecs[i], $sformatf("vec%0d", i));

        // 8-beat burst with no consumer: credits stall reads at 4, command FIFO absorbs 4 more
        for (int k = 0; k < 8; k++) begin
            b_add[k] = 32'h2000 + 32'(8 * k); b_id[k] = 6'd7; b_last[k] = (k == 7);
        end
        acc = '{0, 0}; gcnt = '{0, 0};
        tcdm_gnt_i = 2'b11;
        for (int i = 0; i < 30; i++) begin
            for (int l = 0; l < 2; l++) begin
                trans_req_i[l] = (acc[l] < 8);
                if (acc[l] < 8) drive_beat(l);
            end
            tick();
        end
        trans_req_i = 2'b00;
        chk("burst_accepted", 80'({acc[0], acc[1]}), 80'({32'd8, 32'd8}));
        chk("burst_reads_issued", 80'({gcnt[0], gcnt[1]}), 80'({32'd4, 32'd4}));
        chk("burst_trans_gnt_full", 80'(trans_gnt_o), 80'd0);
        chk("burst_tcdm_stalled", 80'(tcdm_req_o), 80'd0);
        chk("burst_data_gnt", 80'(data_gnt_o), 80'd1);
        pops = 0;
        drain("burst");
        chk("burst_beats", 80'(pops), 80'd8);

        // lane1 held off for 5 cycles while lane0 runs ahead
        for (int k = 0; k < 3; k++) begin
            b_add[k] = 32'h3000 + 32'(8 * k); b_id[k] = 6'(k + 10); b_last[k] = (k == 2);
        end
        acc = '{0, 0}; gcnt = '{0, 0}; pops = 0; gbad = 0;
        for (int i = 0; i < 8; i++) begin
            tcdm_gnt_i = (i < 5) ? 2'b01 : 2'b11;
            if (i < 6 && data_gnt_o) gbad++;
            if (i == 5) chk("skew_grants", 80'({gcnt[0], gcnt[1]}), 80'({32'd3, 32'd0}));
            data_req_i = data_gnt_o;
            for (int l = 0; l < 2; l++) begin
                trans_req_i[l] = (acc[l] < 3);
                if (acc[l] < 3) drive_beat(l);
            end
            tick();
        end
        chk("skew_no_early_gnt", 80'(gbad), 80'd0);
        drain("skew");
        chk("skew_beats", 80'(pops), 80'd3);

        // full throughput: new command every cycle, beat popped every cycle once the pipe fills
        for (int k = 0; k < 20; k++) begin
            b_add[k] = 32'h4000 + 32'(8 * k); b_id[k] = 6'(k); b_last[k] = ((k % 4) == 3);
        end
        acc = '{0, 0}; pops = 0; ones = 0; tg_bad = 0; tr_ones = 0;
        tcdm_gnt_i = 2'b11;
        for (int i = 0; i < 20; i++) begin
            if (i >= 3 && data_gnt_o) ones++;
            if (i >= 1 && tcdm_req_o == 2'b11) tr_ones++;
            if (trans_gnt_o != 2'b11) tg_bad++;
            data_req_i = data_gnt_o;
            trans_req_i = 2'b11;
            drive_beat(0);
            drive_beat(1);
            tick();
        end
        chk("thru_beat_every_cycle", 80'(ones), 80'd17);
        chk("thru_read_every_cycle", 80'(tr_ones), 80'd19);
        chk("thru_trans_gnt_held", 80'(tg_bad), 80'd0);
        drain("thru");
        chk("thru_beats", 80'(pops), 80'd20);

        // randomized traffic on both lanes with random grants and consumer
        for (int k = 0; k < 40; k++) begin
            ra = $urandom();
            b_add[k] = ra & 32'hFFFF_FFF8;
            b_id[k] = 6'($urandom_range(0, 63));
            b_last[k] = 1'($urandom_range(0, 1));
        end
        acc = '{0, 0}; pops = 0; c = 0;
        while ((acc[0] < 40 || acc[1] < 40) && c < 3000) begin
            for (int l = 0; l < 2; l++) begin
                trans_req_i[l] = (acc[l] < 40) && ($urandom_range(0, 1) == 1);
                if (acc[l] < 40) drive_beat(l);
            end
            tcdm_gnt_i = 2'($urandom_range(0, 3));
            data_req_i = data_gnt_o && ($urandom_range(0, 2) != 0);
            tick();
            c++;
        end
        chk("rand_all_sent", 80'({acc[0], acc[1]}), 80'({32'd40, 32'd40}));
        drain("rand");
        chk("rand_beats", 80'(pops), 80'd40);

        // reset with 3 beats buffered and 1 read in flight
        for (int k = 0; k < 4; k++) begin
            b_add[k] = 32'h5000 + 32'(8 * k); b_id[k] = 6'd9; b_last[k] = (k == 3);
        end
        acc = '{0, 0};
        tcdm_gnt_i = 2'b11;
        data_req_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int l = 0; l < 2; l++) begin
                trans_req_i[l] = (acc[l] < 4);
                if (acc[l] < 4) drive_beat(l);
            end
            tick();
        end
        trans_req_i = 2'b00;
        chk("pre_reset_data_gnt", 80'(data_gnt_o), 80'd1);
        chk("pre_reset_rvalid_pending", 80'(tcdm_r_valid_i), 80'(2'b11));
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q0.delete();
        exp_q1.delete();
        tick();
        tick();
        check_reset_outputs("mid_reset_hold");
        rst_ni = 1'b1;
        tick();
        tick();
        chk("post_reset_data_gnt", 80'(data_gnt_o), 80'd0);
        chk("post_reset_tcdm_req", 80'(tcdm_req_o), 80'd0);
        single_beat(vecs[0], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
